// File: rtl/c1_bus_cycle_ctrl_if.sv
// c1_bus_cycle_ctrl_if
//  Bundles the 68k strobe, C1 zone decodes, cart/port wait requests and the
//  DTACK/BERR responses of the bus cycle controller.
//  slave  : the controller (samples strobe/decodes, drives DTACK/BERR/status)
//  master : the 68k / decoder side (drives strobe/decodes, samples responses)
interface c1_bus_cycle_ctrl_if;
    logic       nAS;
    logic       nROM_ZONE;
    logic       nPORT_ZONE;
    logic       nCARD_ZONE;
    logic       nSROM_ZONE;
    logic       nROMWAIT;
    logic       nPWAIT0;
    logic       nPWAIT1;
    logic       PDTACK;
    logic       nDTACK;
    logic       nBERR;
    logic [2:0] CYCLE_ZONE;
    logic       BUSY;

    modport slave (
        input  nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nSROM_ZONE,
        input  nROMWAIT, nPWAIT0, nPWAIT1, PDTACK,
        output nDTACK, nBERR, CYCLE_ZONE, BUSY
    );

    modport master (
        output nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nSROM_ZONE,
        output nROMWAIT, nPWAIT0, nPWAIT1, PDTACK,
        input  nDTACK, nBERR, CYCLE_ZONE, BUSY
    );
endinterface

// File: rtl/c1_bus_cycle_ctrl.sv
// c1_bus_cycle_ctrl
//  Sequences each 68k bus cycle decoded by C1: latches the zone, loads a
//  per-zone wait count plus cart/port wait requests, optionally waits for the
//  port PDTACK handshake, then asserts nDTACK, or nBERR on timeout.
//  Ports:
//   CLK_68KCLK : 68k clock, all state changes on the rising edge
//   nRESET     : asynchronous active-low reset
//   bus        : slave side of c1_bus_cycle_ctrl_if (strobe, zone decodes,
//                wait requests, PDTACK in; nDTACK, nBERR, CYCLE_ZONE, BUSY out)
//  All outputs are flops loaded from the next state, so no input reaches an
//  output combinationally and reset releases nDTACK/nBERR without a glitch.
module c1_bus_cycle_ctrl #(
    parameter int ROM_WAIT  = 3,
    parameter int PORT_WAIT = 3,
    parameter int CARD_WAIT = 2,
    parameter int SROM_WAIT = 3,
    parameter int PDTACK_EN = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                 CLK_68KCLK,
    input  logic                 nRESET,
    c1_bus_cycle_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_EXTWAIT, S_ACK, S_BERR
    } state_t;

    localparam logic [2:0] Z_NONE = 3'd0;
    localparam logic [2:0] Z_ROM  = 3'd1;
    localparam logic [2:0] Z_PORT = 3'd2;
    localparam logic [2:0] Z_CARD = 3'd3;
    localparam logic [2:0] Z_SROM = 3'd4;

    // Timeout fires on the edge that would bring the counter up to TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam bit         PD_EN    = (PDTACK_EN != 0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] zone_q, zone_d;
    logic       dtack_n_q, dtack_n_d;
    logic       berr_n_q, berr_n_d;
    logic       busy_q, busy_d;

    logic [2:0] new_zone;
    logic [3:0] new_wait;
    logic       new_ext;
    logic       ext_q;

    // Zone priority ROM > PORT > CARD > SROM and wait load for a new cycle.
    always_comb begin
        new_zone = Z_NONE;
        new_wait = 4'd0;
        if (!bus.nROM_ZONE) begin
            new_zone = Z_ROM;
            new_wait = 4'(ROM_WAIT) + {3'b000, ~bus.nROMWAIT};
        end else if (!bus.nPORT_ZONE) begin
            new_zone = Z_PORT;
            new_wait = 4'(PORT_WAIT) + {2'b00, ~bus.nPWAIT1, ~bus.nPWAIT0};
        end else if (!bus.nCARD_ZONE) begin
            new_zone = Z_CARD;
            new_wait = 4'(CARD_WAIT);
        end else if (!bus.nSROM_ZONE) begin
            new_zone = Z_SROM;
            new_wait = 4'(SROM_WAIT);
        end
    end

    assign new_ext = PD_EN && (new_zone == Z_PORT);
    assign ext_q   = PD_EN && (zone_q == Z_PORT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        zone_d  = zone_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.nAS) begin
                    zone_d = new_zone;
                    cnt_d  = new_wait;
                    tmo_d  = 8'd0;
                    if (new_wait != 4'd0)
                        state_d = S_WAIT;
                    else if (new_ext && !bus.PDTACK)
                        state_d = S_EXTWAIT;
                    else
                        state_d = S_ACK;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                tmo_d = tmo_q + 8'd1;
                if (bus.nAS)
                    state_d = S_IDLE;
                else if (tmo_q == TMO_LAST)
                    state_d = S_BERR;
                else if (cnt_q == 4'd1)
                    // A PDTACK already high when the count expires acks at once.
                    state_d = (ext_q && !bus.PDTACK) ? S_EXTWAIT : S_ACK;
            end
            S_EXTWAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (bus.nAS)
                    state_d = S_IDLE;
                else if (tmo_q == TMO_LAST)
                    state_d = S_BERR;
                else if (bus.PDTACK)
                    state_d = S_ACK;
            end
            S_ACK, S_BERR: begin
                if (bus.nAS)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE)
            zone_d = Z_NONE;
        dtack_n_d = (state_d != S_ACK);
        berr_n_d  = (state_d != S_BERR);
        busy_d    = (state_d == S_WAIT) || (state_d == S_EXTWAIT);
    end

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            tmo_q     <= 8'd0;
            zone_q    <= Z_NONE;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            zone_q    <= zone_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.nDTACK     = dtack_n_q;
    assign bus.nBERR      = berr_n_q;
    assign bus.CYCLE_ZONE = zone_q;
    assign bus.BUSY       = busy_q;
endmodule
